// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and helpers for the APB requester arbiter: FSM encoding,
// requester-index sizing and the round-robin pointer advance.
package apb_arb_pkg;

   localparam int NUM_REQ_MAX = 4;
   localparam int IDX_W       = $clog2(NUM_REQ_MAX);

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_SETUP,
      ARB_ACCESS,
      ARB_RESP
   } arb_state_e;

   // Pointer moves one past the owner just served, wrapping at num_req.
   function automatic logic [IDX_W-1:0] rr_advance(input logic [IDX_W-1:0] owner,
                                                   input int               num_req);
      if (int'(owner) >= num_req - 1) return '0;
      return owner + IDX_W'(1);
   endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester-side and APB-master-side signals around the arbiter.
// Handshake: a requester holds req[i] with its command until done[i] pulses;
// the arbiter samples req only while idle and captures the command at grant.
interface apb_req_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        done;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      busy;
   logic                      m_transfer;
   logic                      m_write;
   logic [ADDR_W-1:0]         m_addr;
   logic [DATA_W-1:0]         m_wdata;
   logic                      m_ready;
   logic [DATA_W-1:0]         m_rdata;

   // Environment side: requesters plus the APB master's response.
   modport master (
      output req, req_write, req_addr, req_wdata, m_ready, m_rdata,
      input  gnt, done, rsp_rdata, busy, m_transfer, m_write, m_addr, m_wdata
   );

   // Arbiter side.
   modport slave (
      input  req, req_write, req_addr, req_wdata, m_ready, m_rdata,
      output gnt, done, rsp_rdata, busy, m_transfer, m_write, m_addr, m_wdata
   );
endinterface

// File: rtl/apb_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// falling back to the lowest set request when nothing above the pointer is set.
module apb_rr_picker
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [NUM_REQ-1:0] win_oh_o,
   output logic [IDX_W-1:0]   win_idx_o,
   output logic               win_any_o
);

   logic [NUM_REQ-1:0] masked;
   logic [NUM_REQ-1:0] cand;
   logic               found;

   always_comb begin
      masked    = '0;
      win_oh_o  = '0;
      win_idx_o = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         masked[i] = req_i[i] && (i >= int'(rr_ptr_i));
      end
      cand = (|masked) ? masked : req_i;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (cand[i] && !found) begin
            found       = 1'b1;
            win_oh_o[i] = 1'b1;
            win_idx_o   = IDX_W'(i);
         end
      end
      win_any_o = found;
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port between NUM_REQ
// requesters; one transaction in flight, sequenced IDLE/ISSUE/SETUP/ACCESS/RESP.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   apb_req_arbiter_if.slave   bus,
   output arb_state_e         dbg_state_o,
   output logic [IDX_W-1:0]   dbg_rr_ptr_o
);

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               write_q, write_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;

   logic [NUM_REQ-1:0] win_oh;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   logic [ADDR_W-1:0]  addr_sel;
   logic [DATA_W-1:0]  wdata_sel;

   apb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req_i     (bus.req),
      .rr_ptr_i  (rr_ptr_q),
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx),
      .win_any_o (win_any)
   );

   // One-hot AND-OR select of the winner's command.
   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_oh[i]) begin
            addr_sel  |= bus.req_addr[i*ADDR_W +: ADDR_W];
            wdata_sel |= bus.req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= ARB_IDLE;
      else          state_q <= state_d;
   end

   // m_ready is deliberately not looked at in SETUP: early PREADY must not complete.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:   if (win_any) state_d = ARB_ISSUE;
         ARB_ISSUE:  state_d = ARB_SETUP;
         ARB_SETUP:  state_d = ARB_ACCESS;
         ARB_ACCESS: if (bus.m_ready) state_d = ARB_RESP;
         ARB_RESP:   state_d = ARB_IDLE;
         default:    state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      owner_d  = owner_q;
      write_d  = write_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (win_any) begin
               owner_d = win_idx;
               write_d = |(win_oh & bus.req_write);
               addr_d  = addr_sel;
               wdata_d = wdata_sel;
            end
         end
         ARB_ACCESS: if (bus.m_ready && !write_q) rdata_d = bus.m_rdata;
         ARB_RESP:   rr_ptr_d = rr_advance(owner_q, NUM_REQ);
         default: ;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         owner_q  <= '0;
         rr_ptr_q <= '0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   // Outputs decode from registered state only, so done/gnt are glitch-free.
   always_comb begin
      bus.gnt        = '0;
      bus.done       = '0;
      bus.m_transfer = (state_q == ARB_ISSUE);
      bus.busy       = (state_q != ARB_IDLE);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            bus.gnt[i]  = (state_q != ARB_IDLE);
            bus.done[i] = (state_q == ARB_RESP);
         end
      end
   end

   assign bus.m_write   = write_q;
   assign bus.m_addr    = addr_q;
   assign bus.m_wdata   = wdata_q;
   assign bus.rsp_rdata = rdata_q;

   assign dbg_state_o  = state_q;
   assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a reactive APB slave model plus
// hand-computed expectations for grant order, latency, data and reset.
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_req_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();
  arb_state_e dbg_state;
  logic [IDX_W-1:0] dbg_rr_ptr;

  apb_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr_ptr)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // ---------------- slave model ----------------
  // k: 0 = ISSUE cycle, 1 = SETUP, >=2 = ACCESS; -1 = no transfer open.
  int          k = -1;
  int          wait_cnt = 0;
  bit          early_ready = 1'b0;
  logic [31:0] slave_rdata = '0;

  always @(negedge PCLK) begin
    if (!PRESETn)                   k = -1;
    else if (bus.m_transfer)        k = 0;
    else if (k >= 2 && bus.m_ready) k = -1;
    else if (k >= 0)                k = k + 1;
    if (k == 1)                          bus.m_ready = early_ready;
    else if (k >= 2 && (k - 2) >= wait_cnt) bus.m_ready = 1'b1;
    else                                 bus.m_ready = 1'b0;
    bus.m_rdata = slave_rdata;
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_gnt"},   32'(bus.gnt), 32'd0);
    check_eq({tag, "_done"},  32'(bus.done), 32'd0);
    check_eq({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
    check_eq({tag, "_busy"},  32'(bus.busy), 32'd0);
    check_eq({tag, "_xfer"},  32'(bus.m_transfer), 32'd0);
    check_eq({tag, "_mwr"},   32'(bus.m_write), 32'd0);
    check_eq({tag, "_maddr"}, bus.m_addr, 32'd0);
    check_eq({tag, "_mwd"},   bus.m_wdata, 32'd0);
    check_eq({tag, "_rr"},    32'(dbg_rr_ptr), 32'd0);
    check_eq({tag, "_st"},    32'(dbg_state), 32'(ARB_IDLE));
  endtask

  // Called in the IDLE cycle in which the request is visible (cycle 0);
  // returns in the IDLE cycle following RESP (cycle lat+1).
  task automatic run_one(input string tag, input int idx, input int lat,
                         input logic [31:0] exp_addr, input logic exp_write,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                         input bit perturb);
    logic [NR-1:0] g;
    g = NR'(1 << idx);
    for (int c = 1; c <= lat + 1; c++) begin
      tick();
      check_eq({tag, "_xfer"}, 32'(bus.m_transfer), (c == 1) ? 32'd1 : 32'd0);
      if (c <= lat) begin
        check_eq({tag, "_gnt"},  32'(bus.gnt), 32'(g));
        check_eq({tag, "_addr"}, bus.m_addr, exp_addr);
        check_eq({tag, "_wr"},   32'(bus.m_write), 32'(exp_write));
        check_eq({tag, "_wd"},   bus.m_wdata, exp_wdata);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
      end else begin
        check_eq({tag, "_gnt_idle"},  32'(bus.gnt), 32'd0);
        check_eq({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
      end
      check_eq({tag, "_done"}, 32'(bus.done), (c == lat) ? 32'(g) : 32'd0);
      if (c == lat) check_eq({tag, "_rsp"}, bus.rsp_rdata, exp_rdata);
      if (perturb && c == 1) begin
        bus.req[idx]              = 1'b0;
        bus.req_addr[idx*AW +: AW] = ~exp_addr;
        bus.req_wdata[idx*DW +: DW] = ~exp_wdata;
        bus.req_write[idx]        = ~exp_write;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req       = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.m_ready   = 1'b0;
    bus.m_rdata   = '0;

    repeat (3) tick();
    check_reset("rst");
    PRESETn = 1'b1;

    // 1: single read, zero wait -> done 4 cycles after req
    slave_rdata = 32'hA5A5_0001;
    bus.req_addr[31:0]  = 32'h1000_1004;
    bus.req_wdata[31:0] = 32'h0;
    bus.req[0] = 1'b1;
    run_one("t1", 0, 4, 32'h1000_1004, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0);
    bus.req[0] = 1'b0;
    check_eq("t1_rr", 32'(dbg_rr_ptr), 32'd1);

    // 4: requester 1 changes its command and drops req after grant
    slave_rdata = 32'h0BAD_F00D;
    bus.req_addr[63:32]  = 32'h1000_3000;
    bus.req_wdata[63:32] = 32'h4444_4444;
    bus.req_write[1] = 1'b0;
    bus.req[1] = 1'b1;
    run_one("t4", 1, 4, 32'h1000_3000, 1'b0, 32'h4444_4444, 32'h0BAD_F00D, 1'b1);
    check_eq("t4_rr", 32'(dbg_rr_ptr), 32'd0);

    // 2: simultaneous held writes -> order 0,1,0,1
    bus.req_addr  = {32'h1000_2000, 32'h1000_0000};
    bus.req_wdata = {32'h2222_0000, 32'h0000_1111};
    bus.req_write = 2'b11;
    bus.req       = 2'b11;
    run_one("t2a", 0, 4, 32'h1000_0000, 1'b1, 32'h0000_1111, 32'h0BAD_F00D, 1'b0);
    run_one("t2b", 1, 4, 32'h1000_2000, 1'b1, 32'h2222_0000, 32'h0BAD_F00D, 1'b0);
    run_one("t2c", 0, 4, 32'h1000_0000, 1'b1, 32'h0000_1111, 32'h0BAD_F00D, 1'b0);
    run_one("t2d", 1, 4, 32'h1000_2000, 1'b1, 32'h2222_0000, 32'h0BAD_F00D, 1'b0);
    bus.req = 2'b00;

    // 3: PREADY early in SETUP, 3 wait states in ACCESS -> done at cycle 7
    early_ready = 1'b1;
    wait_cnt    = 3;
    slave_rdata = 32'h3333_CCCC;
    bus.req_write[0] = 1'b0;
    bus.req_addr[31:0] = 32'h1000_5008;
    bus.req[0] = 1'b1;
    run_one("t3", 0, 7, 32'h1000_5008, 1'b0, 32'h0000_1111, 32'h3333_CCCC, 1'b0);
    bus.req[0] = 1'b0;
    early_ready = 1'b0;
    wait_cnt    = 0;

    // 5: read 0x1234_5678 then a write; rsp_rdata must keep the read value
    slave_rdata = 32'h1234_5678;
    bus.req_write[1] = 1'b0;
    bus.req_addr[63:32] = 32'h1000_4000;
    bus.req[1] = 1'b1;
    run_one("t5r", 1, 4, 32'h1000_4000, 1'b0, 32'h2222_0000, 32'h1234_5678, 1'b0);
    bus.req[1] = 1'b0;
    slave_rdata = 32'hFFFF_0000;
    bus.req_write[0] = 1'b1;
    bus.req_addr[31:0]  = 32'h1000_4004;
    bus.req_wdata[31:0] = 32'hDEAD_BEEF;
    bus.req[0] = 1'b1;
    run_one("t5w", 0, 4, 32'h1000_4004, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    bus.req[0] = 1'b0;
    check_eq("t5_rr", 32'(dbg_rr_ptr), 32'd1);

    // 6: reset during ACCESS, then both request -> requester 0 wins (rr_ptr back to 0)
    wait_cnt    = 20;
    slave_rdata = 32'h5555_AAAA;
    bus.req_write[1] = 1'b0;
    bus.req_addr[63:32] = 32'h1000_6000;
    bus.req[1] = 1'b1;
    repeat (4) tick();
    check_eq("t6_pre_st", 32'(dbg_state), 32'(ARB_ACCESS));
    PRESETn = 1'b0;
    #1;
    check_reset("t6_rst");
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("t6_hold_done", 32'(bus.done), 32'd0);
      check_eq("t6_hold_busy", 32'(bus.busy), 32'd0);
    end
    wait_cnt    = 0;
    slave_rdata = 32'h7777_0001;
    bus.req_write = 2'b00;
    bus.req_addr[31:0]  = 32'h1000_7000;
    bus.req_wdata[31:0] = 32'h0;
    bus.req = 2'b11;
    PRESETn = 1'b1;
    run_one("t6b", 0, 4, 32'h1000_7000, 1'b0, 32'h0, 32'h7777_0001, 1'b0);
    bus.req = 2'b00;
    check_eq("t6_rr", 32'(dbg_rr_ptr), 32'd1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
